// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MIPS memory-access stage: FSM state encoding,
// datapath widths and the default bus-timeout length used when the
// MEM_TIMEOUT_EN build option is enabled.
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    // Default number of ACCESS cycles without ack before the access is aborted.
    localparam logic [7:0] TIMEOUT_CYCLES_DEF = 8'd255;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

endpackage : mem_stage_pkg

// File: rtl/mem_stage_wb_reg.sv
// ----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. When i_bubble is high the slot is invalidated
// (valid and reg_write cleared) while the payload fields hold their value.
// Otherwise every field loads and the slot is marked valid.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_bubble        insert a bubble instead of loading
//   i_reg_write     register-file write enable for this instruction
//   i_mem_to_reg    write-back mux select
//   i_read_data     loaded word
//   i_alu_result    ALU result
//   i_rd            destination register
//   o_*             registered copies, o_valid marks a real instruction
// ----------------------------------------------------------------------------
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bubble,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic [WORD_W-1:0] i_read_data,
    input  logic [WORD_W-1:0] i_alu_result,
    input  logic [REG_W-1:0]  i_rd,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [WORD_W-1:0] o_read_data,
    output logic [WORD_W-1:0] o_alu_result,
    output logic [REG_W-1:0]  o_rd
);

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [WORD_W-1:0] r_read_data;
    logic [WORD_W-1:0] r_alu_result;
    logic [REG_W-1:0]  r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
        end else if (i_bubble) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_valid      <= 1'b1;
            r_reg_write  <= i_reg_write;
            r_mem_to_reg <= i_mem_to_reg;
            r_read_data  <= i_read_data;
            r_alu_result <= i_alu_result;
            r_rd         <= i_rd;
        end
    end

    assign o_valid      = r_valid;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_rd         = r_rd;

endmodule : mem_wb_reg

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 32-bit MIPS pipeline. Reads the EX/MEM register,
// runs one req/ack data-memory transaction per aligned load/store while
// stalling upstream, resolves the branch and feeds the MEM/WB register.
//
// Build option: MEM_TIMEOUT_EN -- adds an 8-bit ACCESS cycle counter; an access
// with no ack by count == TIMEOUT_CYCLES is aborted and bus_err is set.
// Without it ACCESS waits indefinitely and bus_err is tied low.
// ----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              Zero,
  input  logic [WORD_W-1:0] Add,
  input  logic [WORD_W-1:0] ALUResult,
  input  logic [WORD_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  Mux,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [WORD_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [WORD_W-1:0] wb_read_data,
  output logic [WORD_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_rd,
  output logic              misalign_err,
  output logic              bus_err,
  output mem_state_e        o_dbg_state
);

  // Bus handshake: dmem_req rises on the edge leaving IDLE and stays high,
  // with addr/wdata/we frozen, until the edge on which dmem_ack is sampled
  // high (or the access is aborted). dmem_ack is ignored outside ACCESS.

  mem_state_e        r_state;
  mem_state_e        w_next_state;
  logic              r_req;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_misalign;

  logic              w_mem_op;
  logic              w_aligned;
  logic              w_access;
  logic              w_misalign;
  logic              w_timeout;
  logic              w_stall;
  logic              w_done;
  logic              w_wb_reg_write;
  logic [WORD_W-1:0] w_wb_read_data;

  assign w_mem_op   = MemRead | MemWrite;
  assign w_aligned  = (ALUResult[1:0] == 2'b00);
  assign w_access   = w_mem_op & w_aligned;
  assign w_misalign = (r_state == MEM_IDLE) & w_mem_op & ~w_aligned;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_bus_err;

  assign w_timeout = (r_state == MEM_ACCESS) & ~dmem_ack & (r_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == MEM_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign w_done = (r_state == MEM_ACCESS) & (dmem_ack | w_timeout);

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_access) begin
          w_stall      = 1'b1;
          w_next_state = MEM_ACCESS;
        end
      end
      MEM_ACCESS: begin
        if (w_done) begin
          w_next_state = MEM_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_next_state = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if ((r_state == MEM_IDLE) && w_access) begin
        r_req   <= 1'b1;
        r_we    <= MemWrite;
        r_addr  <= ALUResult;
        r_wdata <= ReadData2;
      end else if (w_done) begin
        r_req <= 1'b0;
      end
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

  // Only a completed read returns bus data; writes (including read+write),
  // aborted accesses and non-memory instructions write back zero.
  assign w_wb_read_data = ((r_state == MEM_ACCESS) && dmem_ack && !r_we) ? dmem_rdata : '0;
  assign w_wb_reg_write = RegWrite & ~w_misalign & ~w_timeout;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_bubble     (w_stall),
    .i_reg_write  (w_wb_reg_write),
    .i_mem_to_reg (MemtoReg),
    .i_read_data  (w_wb_read_data),
    .i_alu_result (ALUResult),
    .i_rd         (Mux),
    .o_valid      (wb_valid),
    .o_reg_write  (wb_reg_write),
    .o_mem_to_reg (wb_mem_to_reg),
    .o_read_data  (wb_read_data),
    .o_alu_result (wb_alu_result),
    .o_rd         (wb_rd)
  );

  assign stall         = w_stall;
  assign pc_src        = Branch & Zero & ~w_stall;
  assign branch_target = Add;
  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign misalign_err  = r_misalign;
  assign o_dbg_state   = r_state;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed test of mem_stage: branch resolution, multi-cycle load, single-cycle
// store, read+write combination, misaligned access, reset during ACCESS and
// (with MEM_TIMEOUT_EN) bus timeout.
// ----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        Branch, MemRead, MemtoReg, MemWrite, RegWrite, Zero;
  logic [31:0] Add, ALUResult, ReadData2;
  logic [4:0]  Mux;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src;
  logic [31:0] branch_target;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_rd;
  logic        misalign_err, bus_err;
  mem_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  mem_stage #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Branch        (Branch),
    .MemRead       (MemRead),
    .MemtoReg      (MemtoReg),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .Zero          (Zero),
    .Add           (Add),
    .ALUResult     (ALUResult),
    .ReadData2     (ReadData2),
    .Mux           (Mux),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_read_data  (wb_read_data),
    .wb_alu_result (wb_alu_result),
    .wb_rd         (wb_rd),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err),
    .o_dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    Zero       = 1'b0;
    Add        = 32'h0;
    ALUResult  = 32'h0;
    ReadData2  = 32'h0;
    Mux        = 5'd0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic m2r, input logic rw,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rdst);
    drive_nop();
    MemRead   = rd;
    MemWrite  = wr;
    MemtoReg  = m2r;
    RegWrite  = rw;
    ALUResult = addr;
    ReadData2 = wdata;
    Mux       = rdst;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e)
    else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, e);
    end
  endtask

  int          stall_cnt;
  logic [31:0] rnd_data;

  initial begin
    drive_nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",      32'(dmem_req), 32'h0);
    chk("rst_addr",     dmem_addr, 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_bus_err",  32'(bus_err), 32'h0);
    chk("rst_state",    32'(dbg_state), 32'(MEM_IDLE));
    rst = 1'b0;
    tick();

    // Taken branch, no memory op
    Branch = 1'b1; Zero = 1'b1; Add = 32'h0000_0040;
    RegWrite = 1'b1; ALUResult = 32'h0000_0055; Mux = 5'd3;
    #1;
    chk("br_pc_src", 32'(pc_src), 32'h1);
    chk("br_target", branch_target, 32'h0000_0040);
    chk("br_stall",  32'(stall), 32'h0);
    tick();
    chk("br_wb_valid", 32'(wb_valid), 32'h1);
    chk("br_wb_alu",   wb_alu_result, 32'h0000_0055);
    chk("br_wb_rd",    32'(wb_rd), 32'd3);
    chk("br_wb_rw",    32'(wb_reg_write), 32'h1);
    Zero = 1'b0;
    #1;
    chk("br_nt_pc_src", 32'(pc_src), 32'h0);
    tick();

    // Load at 0x100, ack on the 4th ACCESS cycle
    drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7);
    #1;
    chk("ld_stall_idle", 32'(stall), 32'h1);
    chk("ld_pc_src_stalled", 32'(pc_src), 32'h0);
    chk("ld_req_pre", 32'(dmem_req), 32'h0);
    tick();
    chk("ld_req",   32'(dmem_req), 32'h1);
    chk("ld_we",    32'(dmem_we), 32'h0);
    chk("ld_addr",  dmem_addr, 32'h0000_0100);
    chk("ld_state", 32'(dbg_state), 32'(MEM_ACCESS));
    for (int k = 0; k < 3; k++) begin
      chk("ld_stall_acc", 32'(stall), 32'h1);
      chk("ld_bubble_v",  32'(wb_valid), 32'h0);
      chk("ld_bubble_rw", 32'(wb_reg_write), 32'h0);
      tick();
    end
    chk("ld_req_hold",  32'(dmem_req), 32'h1);
    chk("ld_addr_hold", dmem_addr, 32'h0000_0100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_ack", 32'(stall), 32'h0);
    tick();
    drive_nop();
    chk("ld_wb_valid", 32'(wb_valid), 32'h1);
    chk("ld_wb_data",  wb_read_data, 32'hDEAD_BEEF);
    chk("ld_wb_rd",    32'(wb_rd), 32'd7);
    chk("ld_wb_m2r",   32'(wb_mem_to_reg), 32'h1);
    chk("ld_wb_rw",    32'(wb_reg_write), 32'h1);
    chk("ld_req_done", 32'(dmem_req), 32'h0);
    chk("ld_state_done", 32'(dbg_state), 32'(MEM_IDLE));

    // Store at 0x104, ack in the first ACCESS cycle
    drive_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h1234_5678, 5'd0);
    #1;
    chk("st_stall_idle", 32'(stall), 32'h1);
    tick();
    chk("st_req",   32'(dmem_req), 32'h1);
    chk("st_we",    32'(dmem_we), 32'h1);
    chk("st_wdata", dmem_wdata, 32'h1234_5678);
    chk("st_addr",  dmem_addr, 32'h0000_0104);
    dmem_ack = 1'b1;
    #1;
    chk("st_stall_ack", 32'(stall), 32'h0);
    tick();
    drive_nop();
    chk("st_wb_valid", 32'(wb_valid), 32'h1);
    chk("st_wb_rw",    32'(wb_reg_write), 32'h0);
    chk("st_req_done", 32'(dmem_req), 32'h0);

    // Read and write together: write happens, loaded word is zero
    drive_mem(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0108, 32'hAAAA_5555, 5'd4);
    tick();
    chk("rw_we",    32'(dmem_we), 32'h1);
    chk("rw_wdata", dmem_wdata, 32'hAAAA_5555);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    drive_nop();
    chk("rw_wb_valid", 32'(wb_valid), 32'h1);
    chk("rw_wb_data",  wb_read_data, 32'h0);

    // Misaligned load at 0x102
    drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd9);
    #1;
    chk("mis_stall", 32'(stall), 32'h0);
    tick();
    drive_nop();
    chk("mis_req",      32'(dmem_req), 32'h0);
    chk("mis_err",      32'(misalign_err), 32'h1);
    chk("mis_wb_valid", 32'(wb_valid), 32'h1);
    chk("mis_wb_rw",    32'(wb_reg_write), 32'h0);
    tick();
    chk("mis_err_sticky", 32'(misalign_err), 32'h1);

    // Reset pulse while in ACCESS
    drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd5);
    tick();
    chk("rstacc_req_pre", 32'(dmem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstacc_req",      32'(dmem_req), 32'h0);
    chk("rstacc_state",    32'(dbg_state), 32'(MEM_IDLE));
    chk("rstacc_wb_valid", 32'(wb_valid), 32'h0);
    chk("rstacc_wb_alu",   wb_alu_result, 32'h0);
    chk("rstacc_misalign", 32'(misalign_err), 32'h0);
    chk("rstacc_addr",     dmem_addr, 32'h0);
    drive_nop();
    #1;
    rst = 1'b0;
    tick();

    // Next load completes normally
    rnd_data = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
    drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd12);
    tick();
    chk("post_req",  32'(dmem_req), 32'h1);
    chk("post_addr", dmem_addr, 32'h0000_0300);
    dmem_ack = 1'b1; dmem_rdata = rnd_data;
    tick();
    drive_nop();
    chk("post_wb_data",  wb_read_data, rnd_data);
    chk("post_wb_rd",    32'(wb_rd), 32'd12);
    chk("post_wb_valid", 32'(wb_valid), 32'h1);

`ifdef MEM_TIMEOUT_EN
    // Timeout: no ack ever; abort when the ACCESS counter reaches 4
    drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd6);
    #1;
    stall_cnt = 0;
    for (int k = 0; k < 20 && stall; k++) begin
      stall_cnt++;
      tick();
    end
    chk("to_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("to_stall_drop",   32'(stall), 32'h0);
    tick();
    drive_nop();
    chk("to_bus_err",  32'(bus_err), 32'h1);
    chk("to_req",      32'(dmem_req), 32'h0);
    chk("to_wb_valid", 32'(wb_valid), 32'h1);
    chk("to_wb_data",  wb_read_data, 32'h0);
    chk("to_wb_rw",    32'(wb_reg_write), 32'h0);
    chk("to_state",    32'(dbg_state), 32'(MEM_IDLE));
`else
    chk("bus_err_tied", 32'(bus_err), 32'h0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_stage
